mult_unit: RTL and testbench

MULT_UNIT -- requirements
Module: mult_unit

---
 rtl/mult_unit_pkg.sv | 15 +
 rtl/mult_unit.sv | 106 ++++++++++
 tb/tb_mult_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mult_unit_pkg.sv
// Shared encodings and defaults for the iterative HI/LO multiply unit.
package mult_unit_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [1:0] REG_NONE = 2'b00;
   localparam logic [1:0] REG_HI   = 2'b01;
   localparam logic [1:0] REG_LO   = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/mult_unit.sv
// Radix-2 shift-add multiplier with HI/LO result registers, mthi/mtlo writes
// and a combinational mfhi/mflo read port. Signed operands run as magnitudes.
//
// state | meaning
// IDLE  | no multiply in flight; HI/LO valid, mt writes accepted
// BUSY  | one shift-add iteration per cycle, counter 0..WIDTH-1
module mult_unit
   import mult_unit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             multStart,
   input  logic             multSigned,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   input  logic [1:0]       mtReg,
   input  logic [1:0]       mfReg,
   output logic             multReady,
   output logic [WIDTH-1:0] mfOut,
   output logic [WIDTH-1:0] hiOut,
   output logic [WIDTH-1:0] loOut
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t               r_state;
   state_t               w_next;
   logic [2*WIDTH-1:0]   r_prod;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_neg;
   logic [CW-1:0]        r_cnt;

   logic [WIDTH-1:0]     w_abs_a;
   logic [WIDTH-1:0]     w_abs_b;
   logic [2*WIDTH-1:0]   w_sum;
   logic [2*WIDTH-1:0]   w_final;
   logic                 w_last;

   // Negating the most negative value wraps to itself, which read as unsigned is the exact magnitude.
   assign w_abs_a = (multSigned && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
   assign w_abs_b = (multSigned && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
   assign w_sum   = r_prod + (r_mplier[0] ? r_mcand : '0);
   assign w_final = r_neg ? -w_sum : w_sum;
   assign w_last  = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (multStart) w_next = BUSY;
         BUSY: begin
            if (multStart)   w_next = BUSY;
            else if (w_last) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prod   <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else if (multStart) begin
         r_prod   <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
         r_mplier <= w_abs_b;
         r_neg    <= multSigned & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
         r_cnt    <= '0;
      end else if (r_state == BUSY) begin
         r_prod   <= w_sum;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
         if (w_last) {r_hi, r_lo} <= w_final;
      end else if (mtReg == REG_HI) begin
         r_hi <= SrcAE;
      end else if (mtReg == REG_LO) begin
         r_lo <= SrcAE;
      end
   end

   assign multReady = (r_state == IDLE);
   assign hiOut     = r_hi;
   assign loOut     = r_lo;

   always_comb begin
      mfOut = '0;
      if (mfReg == REG_HI)      mfOut = r_hi;
      else if (mfReg == REG_LO) mfOut = r_lo;
   end

endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit: a reference model built on native 64-bit
// arithmetic and a cycle countdown, compared every cycle, plus literal checks.
module tb_mult_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          multStart = 1'b0;
   logic          multSigned = 1'b0;
   logic [W-1:0]  SrcAE = '0;
   logic [W-1:0]  SrcBE = '0;
   logic [1:0]    mtReg = 2'b00;
   logic [1:0]    mfReg = 2'b00;
   logic          multReady;
   logic [W-1:0]  mfOut, hiOut, loOut;

   int errors = 0;
   int checks = 0;

   mult_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .multStart(multStart), .multSigned(multSigned),
      .SrcAE(SrcAE), .SrcBE(SrcBE), .mtReg(mtReg), .mfReg(mfReg),
      .multReady(multReady), .mfOut(mfOut), .hiOut(hiOut), .loOut(loOut)
   );

   always #5 clk = ~clk;

   // Reference model: result is known at start, it simply appears WIDTH edges later.
   logic          m_busy = 1'b0;
   int            m_left = 0;
   logic [63:0]   m_res = '0;
   logic [W-1:0]  m_hi = '0;
   logic [W-1:0]  m_lo = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy = 1'b0;
         m_left = 0;
         m_hi   = '0;
         m_lo   = '0;
      end else if (multStart) begin
         m_busy = 1'b1;
         m_left = W;
         if (multSigned)
            m_res = $signed({{32{SrcAE[W-1]}}, SrcAE}) * $signed({{32{SrcBE[W-1]}}, SrcBE});
         else
            m_res = {32'b0, SrcAE} * {32'b0, SrcBE};
      end else if (m_busy) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_busy = 1'b0;
            m_hi   = m_res[63:32];
            m_lo   = m_res[31:0];
         end
      end else if (mtReg == 2'b01) begin
         m_hi = SrcAE;
      end else if (mtReg == 2'b10) begin
         m_lo = SrcAE;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [W-1:0] exp_mf;
      chk("ready", {63'b0, multReady}, {63'b0, ~m_busy});
      chk("hi", {32'b0, hiOut}, {32'b0, m_hi});
      chk("lo", {32'b0, loOut}, {32'b0, m_lo});
      if (!m_busy) begin
         exp_mf = (mfReg == 2'b01) ? m_hi : (mfReg == 2'b10) ? m_lo : '0;
         chk("mfOut", {32'b0, mfOut}, {32'b0, exp_mf});
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Pulses multStart for one edge, then counts cycles with multReady low.
   task automatic run_mult(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int low_cycles);
      multStart  = 1'b1;
      multSigned = sgn;
      SrcAE      = a;
      SrcBE      = b;
      step();
      multStart  = 1'b0;
      low_cycles = 0;
      while (!multReady && low_cycles < 100) begin
         low_cycles++;
         step();
      end
   endtask

   int n;

   initial begin
      mfReg = 2'b01;
      #1;
      chk("rst_ready", {63'b0, multReady}, 64'd1);
      chk("rst_hi", {32'b0, hiOut}, 64'd0);
      chk("rst_lo", {32'b0, loOut}, 64'd0);
      chk("rst_mf_hi", {32'b0, mfOut}, 64'd0);
      mfReg = 2'b10;
      #1;
      chk("rst_mf_lo", {32'b0, mfOut}, 64'd0);
      step();
      reset = 1'b0;
      step();

      run_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
      chk("u_ff_lat", 64'(n), 64'd32);
      chk("u_ff_hi", {32'b0, hiOut}, 64'hFFFF_FFFE);
      chk("u_ff_lo", {32'b0, loOut}, 64'h0000_0001);

      run_mult(1'b1, 32'hFFFF_FFFD, 32'd7, n);
      chk("s_m3x7_hi", {32'b0, hiOut}, 64'hFFFF_FFFF);
      chk("s_m3x7_lo", {32'b0, loOut}, 64'hFFFF_FFEB);
      mfReg = 2'b10;
      #1;
      chk("s_m3x7_mf", {32'b0, mfOut}, 64'hFFFF_FFEB);

      run_mult(1'b1, 32'h8000_0000, 32'h8000_0000, n);
      chk("s_min_hi", {32'b0, hiOut}, 64'h4000_0000);
      chk("s_min_lo", {32'b0, loOut}, 64'h0000_0000);

      // Restart mid-flight with an ignored mthi pulse.
      multStart = 1'b1; multSigned = 1'b0; SrcAE = 32'd2; SrcBE = 32'd3;
      step();
      multStart = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i == 4) begin mtReg = 2'b01; SrcAE = 32'hDEAD_BEEF; end
         else mtReg = 2'b00;
         step();
      end
      mtReg = 2'b00;
      chk("mt_busy_hi", {32'b0, hiOut}, 64'h4000_0000);
      run_mult(1'b0, 32'd5, 32'd6, n);
      chk("restart_lat", 64'(n), 64'd32);
      chk("restart_lo", {32'b0, loOut}, 64'd30);
      chk("restart_hi", {32'b0, hiOut}, 64'd0);

      // mthi in IDLE, then multStart wins over mtlo in the same cycle.
      mtReg = 2'b01; SrcAE = 32'h1234_5678;
      step();
      mtReg = 2'b00;
      chk("mthi_idle", {32'b0, hiOut}, 64'h1234_5678);
      mtReg = 2'b10;
      run_mult(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
      mtReg = 2'b00;
      chk("start_wins_lo", {32'b0, loOut}, 64'd1);
      chk("start_wins_hi", {32'b0, hiOut}, 64'd0);

      run_mult(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, n);
      chk("s_max_min_hi", {32'b0, hiOut}, 64'hC000_0000);
      chk("s_max_min_lo", {32'b0, loOut}, 64'h8000_0000);
      run_mult(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, n);
      run_mult(1'b1, 32'hFFFF_FF00, 32'h0000_0100, n);

      // Reset mid-operation discards the result.
      multStart = 1'b1; multSigned = 1'b0; SrcAE = 32'h1234; SrcBE = 32'h10;
      step();
      multStart = 1'b0;
      for (int i = 0; i < 14; i++) step();
      reset = 1'b1;
      #1;
      chk("midrst_ready", {63'b0, multReady}, 64'd1);
      chk("midrst_hi", {32'b0, hiOut}, 64'd0);
      chk("midrst_lo", {32'b0, loOut}, 64'd0);
      step();
      reset = 1'b0;
      mtReg = 2'b10; SrcAE = 32'hA5A5_A5A5;
      step();
      mtReg = 2'b00;
      chk("post_rst_mtlo", {32'b0, loOut}, 64'hA5A5_A5A5);
      run_mult(1'b0, 32'd9, 32'd11, n);
      chk("post_rst_lo", {32'b0, loOut}, 64'd99);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
